// File: rtl/mux_scan_reg.sv
`default_nettype none
// mux_scan_reg -- registered N:1 channel mux; manual select or dwell-timed round-robin scan.
// Rev 1.0
module mux_scan_reg #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] X,
  input  logic [SEL_W-1:0]          C,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      valid,
  output logic                      wrap
);

  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   NUM_CH     = (SEL_W + 1)'(CHANNELS);
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DW_W-1:0]  dwell_cnt;
  logic [DW_W-1:0]  dwell_next;
  logic [SEL_W-1:0] sel_next;
  logic             valid_next;
  logic             wrap_next;
  logic             zero_out;
  logic [WIDTH-1:0] chan [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = X[k*WIDTH +: WIDTH];
  end

  always_comb begin
    state_next = mode ? SCAN : MANUAL;
    sel_next   = cur_sel;
    dwell_next = dwell_cnt;
    valid_next = 1'b1;
    wrap_next  = 1'b0;
    zero_out   = 1'b0;
    if (!mode) begin
      // Leaving SCAN lands here too, so a pending wrap is dropped on the same edge.
      dwell_next = '0;
      if ({1'b0, C} >= NUM_CH) begin
        zero_out   = 1'b1;
        valid_next = 1'b0;
      end else begin
        sel_next = C;
      end
    end else if (state == MANUAL) begin
      sel_next   = '0;
      dwell_next = '0;
    end else if (!hold) begin
      if (dwell_cnt == LAST_DWELL) begin
        dwell_next = '0;
        if (cur_sel == LAST_CH) begin
          sel_next  = '0;
          wrap_next = 1'b1;
        end else begin
          sel_next = cur_sel + SEL_W'(1);
        end
      end else begin
        dwell_next = dwell_cnt + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MANUAL;
      dwell_cnt <= '0;
      cur_sel   <= '0;
      Y         <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_next;
      cur_sel   <= sel_next;
      Y         <= zero_out ? '0 : chan[sel_next];
      valid     <= valid_next;
      wrap      <= wrap_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_reg.sv
`default_nettype none
// tb_mux_scan_reg -- directed checks of mux_scan_reg: 4-channel DWELL=3 and 5-channel DWELL=1 instances.
module tb_mux_scan_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, CHANNELS=4, DWELL=3
  logic        reset_a, mode_a, hold_a;
  logic [1:0]  c_a;
  logic [31:0] x_a;
  logic [7:0]  y_a;
  logic [1:0]  sel_a;
  logic        valid_a, wrap_a;

  // Instance B: WIDTH=8, CHANNELS=5 (SEL_W=3), DWELL=1
  logic        reset_b, mode_b, hold_b;
  logic [2:0]  c_b;
  logic [39:0] x_b;
  logic [7:0]  y_b;
  logic [2:0]  sel_b;
  logic        valid_b, wrap_b;

  mux_scan_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk(clk), .reset(reset_a), .X(x_a), .C(c_a), .mode(mode_a), .hold(hold_a),
    .Y(y_a), .cur_sel(sel_a), .valid(valid_a), .wrap(wrap_a)
  );

  mux_scan_reg #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset_b), .X(x_b), .C(c_b), .mode(mode_b), .hold(hold_b),
    .Y(y_b), .cur_sel(sel_b), .valid(valid_b), .wrap(wrap_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        md;
    logic        hd;
    logic [1:0]  c;
    logic [31:0] x;
    logic [7:0]  y;
    logic [1:0]  sel;
    logic        v;
    logic        w;
  } vec_t;

  localparam logic [31:0] XA = 32'h4433_2211;
  localparam logic [39:0] XB = 40'h55_4433_2211;

  vec_t va [13];

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic step_a(input logic r, input logic m, input logic h, input logic [1:0] c, input logic [31:0] x);
    reset_a = r; mode_a = m; hold_a = h; c_a = c; x_a = x;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, input logic m, input logic [2:0] c);
    reset_b = r; mode_b = m; hold_b = 1'b0; c_b = c; x_b = XB;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int idx, input logic [7:0] ey, input logic [1:0] es,
                         input logic ev, input logic ew);
    chk({tag, ".Y"},       idx, 32'(y_a),     32'(ey));
    chk({tag, ".cur_sel"}, idx, 32'(sel_a),   32'(es));
    chk({tag, ".valid"},   idx, 32'(valid_a), 32'(ev));
    chk({tag, ".wrap"},    idx, 32'(wrap_a),  32'(ew));
  endtask

  task automatic check_b(input string tag, input int idx, input logic [7:0] ey, input logic [2:0] es,
                         input logic ev, input logic ew);
    chk({tag, ".Y"},       idx, 32'(y_b),     32'(ey));
    chk({tag, ".cur_sel"}, idx, 32'(sel_b),   32'(es));
    chk({tag, ".valid"},   idx, 32'(valid_b), 32'(ev));
    chk({tag, ".wrap"},    idx, 32'(wrap_b),  32'(ew));
  endtask

  function automatic logic [7:0] lane_a(input logic [31:0] x, input int s);
    return x[s*8 +: 8];
  endfunction

  function automatic logic [7:0] lane_b(input logic [39:0] x, input int s);
    return x[s*8 +: 8];
  endfunction

  initial begin
    logic [31:0] xr;
    logic [1:0]  es;

    reset_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; c_a = '0; x_a = XA;
    reset_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; c_b = '0; x_b = XB;

    //          rst   md    hd    c     x             y      sel   v     w
    va[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, XA,           8'h00, 2'd0, 1'b0, 1'b0};
    va[1]  = '{1'b0, 1'b0, 1'b0, 2'd2, XA,           8'h33, 2'd2, 1'b1, 1'b0};
    va[2]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h44AA2211, 8'hAA, 2'd2, 1'b1, 1'b0};
    va[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, XA,           8'h11, 2'd0, 1'b1, 1'b0};
    va[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, XA,           8'h44, 2'd3, 1'b1, 1'b0};
    va[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, XA,           8'h11, 2'd0, 1'b1, 1'b0};
    va[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, XA,           8'h11, 2'd0, 1'b1, 1'b0};
    va[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, XA,           8'h11, 2'd0, 1'b1, 1'b0};
    va[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, XA,           8'h22, 2'd1, 1'b1, 1'b0};
    va[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, XA,           8'h44, 2'd3, 1'b1, 1'b0};
    va[10] = '{1'b0, 1'b1, 1'b0, 2'd3, XA,           8'h11, 2'd0, 1'b1, 1'b0};
    va[11] = '{1'b1, 1'b1, 1'b0, 2'd3, XA,           8'h00, 2'd0, 1'b0, 1'b0};
    va[12] = '{1'b0, 1'b1, 1'b0, 2'd3, XA,           8'h11, 2'd0, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step_a(va[i].rst, va[i].md, va[i].hd, va[i].c, va[i].x);
      check_a("vec", i, va[i].y, va[i].sel, va[i].v, va[i].w);
    end

    // Full scan lap from a fresh reset, random data every cycle; ends at cur_sel=1, dwell=1.
    step_a(1'b1, 1'b0, 1'b0, 2'd0, XA);
    for (int i = 0; i <= 16; i++) begin
      xr = $urandom();
      step_a(1'b0, 1'b1, 1'b0, 2'd3, xr);
      es = 2'((i / 3) % 4);
      check_a("scan", i, lane_a(xr, int'(es)), es, 1'b1, (i == 12));
    end

    // Hold for five edges: index frozen, data still live, C ignored.
    for (int i = 0; i < 5; i++) begin
      xr = $urandom();
      step_a(1'b0, 1'b1, 1'b1, 2'd2, xr);
      check_a("hold", i, lane_a(xr, 1), 2'd1, 1'b1, 1'b0);
    end
    step_a(1'b0, 1'b1, 1'b0, 2'd0, XA);
    check_a("unhold", 0, 8'h22, 2'd1, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b0, 2'd0, XA);
    check_a("unhold", 1, 8'h33, 2'd2, 1'b1, 1'b0);

    // Reach channel 3, then reset mid-scan with mode held high.
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0, 2'd0, XA);
    check_a("at3", 0, 8'h44, 2'd3, 1'b1, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 2'd0, XA);
    check_a("rst_mid", 0, 8'h00, 2'd0, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 1'b0, 2'd0, XA);
    check_a("restart", 0, 8'h11, 2'd0, 1'b1, 1'b0);

    // Advance to the last dwell cycle of channel 3, then leave SCAN: wrap must not appear.
    for (int k = 1; k <= 11; k++) begin
      step_a(1'b0, 1'b1, 1'b0, 2'd0, XA);
      es = 2'(k / 3);
      check_a("lap2", k, lane_a(XA, int'(es)), es, 1'b1, 1'b0);
    end
    step_a(1'b0, 1'b0, 1'b0, 2'd1, XA);
    check_a("drop_wrap", 0, 8'h22, 2'd1, 1'b1, 1'b0);

    // Instance B: non-power-of-2 channel count.
    step_b(1'b1, 1'b0, 3'd0);
    check_b("b_rst", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 3'd4);
    check_b("b_man", 4, 8'h55, 3'd4, 1'b1, 1'b0);
    for (int c = 5; c <= 7; c++) begin
      step_b(1'b0, 1'b0, 3'(c));
      check_b("b_bad", c, 8'h00, 3'd4, 1'b0, 1'b0);
    end
    step_b(1'b0, 1'b0, 3'd1);
    check_b("b_man", 1, 8'h22, 3'd1, 1'b1, 1'b0);
    step_b(1'b0, 1'b1, 3'd6);
    check_b("b_scan", 0, 8'h11, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step_b(1'b0, 1'b1, 3'd6);
      check_b("b_scan", i, lane_b(XB, i % 5), 3'(i % 5), 1'b1, ((i % 5) == 0));
    end
    step_b(1'b0, 1'b0, 3'd6);
    check_b("b_exit_bad", 0, 8'h00, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
